sparsity_expander: RTL
======================

SPARSITY_EXPANDER -- requirements
Module: sparsity_expander

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning width of one element.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, meaning elements per dense block; only 4 is supported.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports mask_valid input 1, mask_ready output 1, mask_in input BLOCK_SIZE: per-block keep mask, bit i set means lane i was kept.
REQ-006 SHALL have ports val_valid input 1, val_ready output 1, val_in input DATA_WIDTH: one kept value per beat.
REQ-007 SHALL have ports out_valid output 1, out_ready input 1, data_out output DATA_WIDTH*BLOCK_SIZE (lane i at bits [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]), mask_out output BLOCK_SIZE.

Function
REQ-008 SHALL transfer on any channel only on a cycle where valid and ready are both high; valid/data SHALL be held by the sender until transfer.
REQ-009 SHALL implement FSM IDLE, COLLECT, EMIT; reset state IDLE.
REQ-010 IDLE: mask_ready=1, val_ready=0; on mask handshake, latch mask, clear data register to zero, load remaining-count = popcount(mask_in).
REQ-011 IDLE->COLLECT when popcount>=1; IDLE->EMIT directly when mask_in=0 (all-zero block, no value beats consumed).
REQ-012 COLLECT: mask_ready=0, val_ready=1; each value handshake writes val_in to the lowest-index still-unfilled set lane of the latched mask, decrements remaining-count.
REQ-013 COLLECT->EMIT on the handshake that decrements remaining-count from 1 to 0; out_valid SHALL rise the next cycle.
REQ-014 EMIT: out_valid=1, mask_ready=0, val_ready=0; data_out holds values in kept lanes, zero in dropped lanes; mask_out = latched mask.
REQ-015 EMIT->IDLE on output handshake; data_out/mask_out SHALL remain stable while out_valid=1 and out_ready=0.
REQ-016 Latency: out_valid asserted 1 cycle after the last value handshake (or after the mask handshake for mask 0); minimum block period popcount+2 cycles.
REQ-017 val_valid in IDLE or EMIT SHALL be ignored (not consumed); mask_valid in COLLECT or EMIT SHALL be ignored.
REQ-018 Values SHALL be written unmodified (sign preserved); no arithmetic on data.

Reset
REQ-019 On reset_n low, asynchronously: state IDLE, out_valid=0, data_out=0, mask_out=0, remaining-count=0, val_ready=0, mask_ready=0 while asserted; mask_ready=1 from the first clk edge after deassertion.
REQ-020 Reset mid-COLLECT or mid-EMIT SHALL discard the partial/pending block; no output produced for it.

Configuration
REQ-021 With macro SPARSITY_EXPANDER_STATS_EN defined: 32-bit output stat_blocks (count of output handshakes) and 32-bit output stat_zero_lanes (sum of cleared mask bits per output handshake), both saturating at all-ones, cleared by reset.
REQ-022 Without SPARSITY_EXPANDER_STATS_EN: the stat ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-023 Shared package SHALL hold the FSM state encoding (IDLE=2'd0, COLLECT=2'd1, EMIT=2'd2) and the mask width constant; the sparsity pattern encodings used by the selector (2:4, 1:4, 1:8, adaptive) SHALL move there too.
REQ-024 One sub-module sparsity_lane_pick SHALL be natural: combinational lowest-unfilled-set-lane one-hot from (mask, filled vector).

Verification
REQ-025 mask 4'b0101, values 0x11, 0x7F -> data_out 0x007F0011, mask_out 0101, out_valid 1 cycle after 2nd value.
REQ-026 mask 4'b0000 -> no val_ready, out_valid next cycle, data_out 0, mask_out 0.
REQ-027 mask 4'b1111, values 0x01,0x80,0xFF,0x02 with val_valid gaps -> data_out 0x02FF8001.
REQ-028 mask 4'b1000, value 0x9C, out_ready low 5 cycles -> data_out 0x9C000000 stable for 5 cycles, then one handshake, back to IDLE.
REQ-029 Reset asserted after 1 of 2 values of mask 4'b0011 -> out_valid 0 immediately; next block mask 4'b0001 value 0x05 -> data_out 0x00000005.
REQ-030 SPARSITY_EXPANDER_STATS_EN builds: blocks from REQ-025..028 -> stat_blocks 4, stat_zero_lanes 2+4+0+3 = 9.

Source files
------------

// File: rtl/sparsity_expander_pkg.sv
// -----------------------------------------------------------------------------
// sparsity_expander_pkg
// Shared definitions for the sparsity expander slice:
//   - FSM state encoding (IDLE / COLLECT / EMIT)
//   - mask width and remaining-count width constants
//   - sparsity pattern encodings used by the pattern selector
//   - popcount and 32-bit saturating-add helpers
// -----------------------------------------------------------------------------
package sparsity_expander_pkg;

    // Lanes per dense block; the expander only supports 4.
    localparam int MASK_W = 4;

    // Wide enough to hold popcount of a full mask (0..4).
    localparam int CNT_W = 3;

    localparam logic [CNT_W-1:0] CNT_ONE = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_e;

    // Structured-sparsity patterns understood by the upstream selector.
    typedef enum logic [1:0] {
        SP_2_OF_4    = 2'd0,
        SP_1_OF_4    = 2'd1,
        SP_1_OF_8    = 2'd2,
        SP_ADAPTIVE  = 2'd3
    } sparsity_pattern_e;

    // Number of kept lanes in a block mask.
    function automatic logic [CNT_W-1:0] popcount_mask(input logic [MASK_W-1:0] m);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < MASK_W; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, m[i]};
        end
        return c;
    endfunction

    // 32-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[32]) begin
            return 32'hFFFF_FFFF;
        end else begin
            return sum[31:0];
        end
    endfunction

endpackage

// File: rtl/sparsity_expander_lane_pick.sv
// -----------------------------------------------------------------------------
// sparsity_lane_pick
// Combinational selector returning a one-hot vector marking the lowest-index
// lane that is set in the keep mask but not yet filled.
// Ports:
//   mask    - latched keep mask of the current block
//   filled  - lanes already written in the current block
//   pick    - one-hot of the next lane to write (all-zero when none left)
// -----------------------------------------------------------------------------
module sparsity_lane_pick
    import sparsity_expander_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    input  logic [MASK_W-1:0] filled,
    output logic [MASK_W-1:0] pick
);

    logic [MASK_W-1:0] cand_s;

    // Isolate the lowest set bit of the candidate lanes (x & -x).
    always_comb begin
        cand_s = mask & ~filled;
        pick   = cand_s & (~cand_s + {{(MASK_W-1){1'b0}}, 1'b1});
    end

endmodule

// File: rtl/sparsity_expander.sv
// -----------------------------------------------------------------------------
// sparsity_expander
// Rebuilds a dense block of BLOCK_SIZE elements from a keep mask followed by
// one beat per kept value. Dropped lanes come out as zero.
// Ports:
//   clk, reset_n                        - clock, async active-low reset
//   mask_valid/mask_ready/mask_in       - per-block keep mask channel
//   val_valid/val_ready/val_in          - kept-value channel, one value per beat
//   out_valid/out_ready/data_out/mask_out - expanded block output channel
//   stat_blocks, stat_zero_lanes        - only with SPARSITY_EXPANDER_STATS_EN:
//                                         saturating output-block and
//                                         dropped-lane counters
// Optional feature macro: SPARSITY_EXPANDER_STATS_EN
// -----------------------------------------------------------------------------
module sparsity_expander
    import sparsity_expander_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             mask_valid,
    output logic                             mask_ready,
    input  logic [BLOCK_SIZE-1:0]            mask_in,
    input  logic                             val_valid,
    output logic                             val_ready,
    input  logic [DATA_WIDTH-1:0]            val_in,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*BLOCK_SIZE-1:0] data_out,
    output logic [BLOCK_SIZE-1:0]            mask_out
`ifdef SPARSITY_EXPANDER_STATS_EN
    ,
    output logic [31:0]                      stat_blocks,
    output logic [31:0]                      stat_zero_lanes
`endif
);

    state_e                          state_r;
    state_e                          state_nxt_s;
    logic [BLOCK_SIZE-1:0]           mask_r;
    logic [BLOCK_SIZE-1:0]           filled_r;
    logic [DATA_WIDTH*BLOCK_SIZE-1:0] data_r;
    logic [CNT_W-1:0]                rem_cnt_r;
    logic                            mask_ready_r;
    logic                            val_ready_r;
    logic                            out_valid_r;
    logic [BLOCK_SIZE-1:0]           pick_s;
    logic                            mask_hs_s;
    logic                            val_hs_s;
    logic                            out_hs_s;

    // Handshakes: ready is only ever high in the state that owns the channel,
    // so stray valids in other states are never consumed.
    always_comb begin
        mask_hs_s = mask_valid & mask_ready_r;
        val_hs_s  = val_valid  & val_ready_r;
        out_hs_s  = out_valid_r & out_ready;
    end

    sparsity_lane_pick u_lane_pick (
        .mask   (mask_r),
        .filled (filled_r),
        .pick   (pick_s)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mask_hs_s) begin
                    if (mask_in == '0) begin
                        state_nxt_s = ST_EMIT;
                    end else begin
                        state_nxt_s = ST_COLLECT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (val_hs_s && (rem_cnt_r == CNT_ONE)) begin
                    state_nxt_s = ST_EMIT;
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_EMIT: begin
                if (out_hs_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EMIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs are registered from the next state, so they are all
    // low while reset is held and mask_ready comes up on the first edge after.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_ready_r <= 1'b0;
            val_ready_r  <= 1'b0;
            out_valid_r  <= 1'b0;
        end else begin
            mask_ready_r <= (state_nxt_s == ST_IDLE);
            val_ready_r  <= (state_nxt_s == ST_COLLECT);
            out_valid_r  <= (state_nxt_s == ST_EMIT);
        end
    end

    // Block datapath: latch mask and clear on mask accept, then drop each
    // value into the lowest still-empty kept lane. Held untouched in EMIT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_r    <= '0;
            filled_r  <= '0;
            data_r    <= '0;
            rem_cnt_r <= '0;
        end else if (mask_hs_s) begin
            mask_r    <= mask_in;
            filled_r  <= '0;
            data_r    <= '0;
            rem_cnt_r <= popcount_mask(mask_in);
        end else if (val_hs_s) begin
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (pick_s[i]) begin
                    data_r[i*DATA_WIDTH +: DATA_WIDTH] <= val_in;
                end
            end
            filled_r  <= filled_r | pick_s;
            rem_cnt_r <= rem_cnt_r - CNT_ONE;
        end else begin
            mask_r    <= mask_r;
            filled_r  <= filled_r;
            data_r    <= data_r;
            rem_cnt_r <= rem_cnt_r;
        end
    end

    assign mask_ready = mask_ready_r;
    assign val_ready  = val_ready_r;
    assign out_valid  = out_valid_r;
    assign data_out   = data_r;
    assign mask_out   = mask_r;

`ifdef SPARSITY_EXPANDER_STATS_EN
    logic [31:0]      stat_blocks_r;
    logic [31:0]      stat_zero_lanes_r;
    logic [CNT_W-1:0] zero_lanes_s;

    // Dropped lanes of the block currently being emitted.
    always_comb begin
        zero_lanes_s = CNT_W'(MASK_W) - popcount_mask(mask_r);
    end

    // Saturating statistics, updated once per output handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_blocks_r     <= 32'd0;
            stat_zero_lanes_r <= 32'd0;
        end else if (out_hs_s) begin
            stat_blocks_r     <= sat_add32(stat_blocks_r, 32'd1);
            stat_zero_lanes_r <= sat_add32(stat_zero_lanes_r, {29'd0, zero_lanes_s});
        end else begin
            stat_blocks_r     <= stat_blocks_r;
            stat_zero_lanes_r <= stat_zero_lanes_r;
        end
    end

    assign stat_blocks     = stat_blocks_r;
    assign stat_zero_lanes = stat_zero_lanes_r;
`endif

endmodule
